// File: rtl/tenyr_pkg.sv
// -----------------------------------------------------------------------------
// tenyr_pkg
// Shared definitions for the tenyr core and its ALU:
//   - halt vector bit positions and width
//   - instruction field layout, type (t) and data-direction (dd) encodings
//   - ALU op-code constants
//   - register index constants and the reset vector default
//   - core FSM state enum
// -----------------------------------------------------------------------------
package tenyr_pkg;

  // Halt vector: any set bit stalls the core in FETCH.
  localparam int HALT_TENYR    = 0;
  localparam int HALT_EXTERNAL = 1;
  localparam int HALTTYPE_W    = 2;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_1000;
  localparam int          RAM_DEPTH_DEFAULT    = 16384;

  // Register indices: A is hard-wired zero, P is the program counter.
  localparam logic [3:0] REG_A = 4'd0;
  localparam logic [3:0] REG_P = 4'd15;

  // Operand arrangement selected by the t field.
  typedef enum logic [1:0] {
    T_X_OP_YI = 2'd0,   // X op (Y + I)
    T_X_OP_IY = 2'd1,   // X op (I + Y)
    T_I_OP_XY = 2'd2,   // I op (X + Y)
    T_X_I20   = 2'd3    // X + I20
  } t_e;

  // Data movement selected by the dd field.
  typedef enum logic [1:0] {
    DD_REG       = 2'd0,  // Z <- rhs
    DD_STORE_Z   = 2'd1,  // mem[rhs] <- Z
    DD_STORE_RHS = 2'd2,  // mem[Z] <- rhs
    DD_LOAD      = 2'd3   // Z <- mem[rhs]
  } dd_e;

  typedef enum logic [3:0] {
    OP_OR   = 4'h0,
    OP_AND  = 4'h1,
    OP_XOR  = 4'h2,
    OP_SHRA = 4'h3,
    OP_ADD  = 4'h4,
    OP_MUL  = 4'h5,
    OP_EQ   = 4'h6,
    OP_LT   = 4'h7,
    OP_ORN  = 4'h8,
    OP_ANDN = 4'h9,
    OP_PACK = 4'hA,
    OP_TEST = 4'hB,
    OP_SUB  = 4'hC,
    OP_SHL  = 4'hD,
    OP_GE   = 4'hE,
    OP_SHR  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Instruction word layout. For t=3 the y/op/imm12 bits together form imm20.
  typedef struct packed {
    logic [1:0]  t;
    logic [1:0]  dd;
    logic [3:0]  z;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  op;
    logic [11:0] imm12;
  } insn_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] sext20(input logic [19:0] v);
    return {{12{v[19]}}, v};
  endfunction

endpackage

// File: rtl/tenyr_alu.sv
// -----------------------------------------------------------------------------
// tenyr_alu
// Purely combinational 32-bit ALU for the tenyr core.
// Ports:
//   op_i [3:0]  operation select (op_e encoding)
//   a_i  [31:0] left operand
//   b_i  [31:0] right operand; b_i[4:0] is the shift / bit-test amount
//   y_o  [31:0] result; compares and bit-test give all-ones for true, 0 for false
// All arithmetic wraps at 32 bits.
// -----------------------------------------------------------------------------
module tenyr_alu
  import tenyr_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic [4:0] sh;
  assign sh = b_i[4:0];

  always_comb begin
    y_o = 32'h0;
    case (op_e'(op_i))
      OP_OR:   y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SHRA: y_o = $unsigned($signed(a_i) >>> sh);
      OP_ADD:  y_o = a_i + b_i;
      OP_MUL:  y_o = a_i * b_i;
      OP_EQ:   y_o = {32{a_i == b_i}};
      OP_LT:   y_o = {32{$signed(a_i) < $signed(b_i)}};
      OP_ORN:  y_o = a_i | ~b_i;
      OP_ANDN: y_o = a_i & ~b_i;
      OP_PACK: y_o = (a_i << 12) | {20'h0, b_i[11:0]};
      // (a >> n) & 1 is simply bit n of a.
      OP_TEST: y_o = {32{a_i[sh]}};
      OP_SUB:  y_o = a_i - b_i;
      OP_SHL:  y_o = a_i << sh;
      OP_GE:   y_o = {32{$signed(a_i) >= $signed(b_i)}};
      OP_SHR:  y_o = a_i >> sh;
      default: y_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/tenyr.sv
// -----------------------------------------------------------------------------
// tenyr
// Self-contained tenyr system: one 32-bit tenyr core plus a unified,
// word-addressed instruction/data RAM. The program image is preloaded into
// ram_q by the simulation loader; results are observed through the internal
// register file (regs_q), RAM (ram_q) and FSM state (state_q).
// Ports:
//   clk      system clock, all state changes on its rising edge
//   reset_n  synchronous active-low reset
//   halt     halt requests (bit HALT_TENYR, bit HALT_EXTERNAL); any set bit
//            holds the core in FETCH
// Parameters:
//   RAM_DEPTH     number of 32-bit words; must be a power of two so that the
//                 low address bits implement addr mod RAM_DEPTH
//   RESET_VECTOR  value loaded into P on reset
// Timing: FETCH -> EXEC (2 cycles per instruction), loads add a LOAD cycle.
// -----------------------------------------------------------------------------
module tenyr
  import tenyr_pkg::*;
#(
  parameter int          RAM_DEPTH    = RAM_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input logic                  clk,
  input logic                  reset_n,
  input logic [HALTTYPE_W-1:0] halt
);

  localparam int AW = $clog2(RAM_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q  [RAM_DEPTH];
  logic [31:0] rdata_q;            // RAM read port: instruction or load data
  logic [31:0] regs_q [16];        // A..P; regs_q[15] is P, regs_q[0] stays 0
  state_e      state_q;
  logic [3:0]  ld_z_q;             // load destination held across LOAD

  // ---------------------------------------------------------------------------
  // Decode (valid while state_q == ST_EXEC, when rdata_q holds the instruction)
  // ---------------------------------------------------------------------------
  insn_t       ir;
  logic [31:0] p_plus1;
  logic [31:0] x_val, y_val, z_val;
  logic [31:0] imm12_val, imm20_val;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [31:0] rhs;

  assign ir        = insn_t'(rdata_q);
  assign p_plus1   = regs_q[REG_P] + 32'd1;
  assign imm12_val = sext12(ir.imm12);
  assign imm20_val = sext20({ir.y, ir.op, ir.imm12});

  // Operand reads: A is zero, P reads as the address of the next word.
  always_comb begin
    x_val = regs_q[ir.x];
    y_val = regs_q[ir.y];
    z_val = regs_q[ir.z];
    if (ir.x == REG_A) x_val = 32'h0;
    if (ir.y == REG_A) y_val = 32'h0;
    if (ir.z == REG_A) z_val = 32'h0;
    if (ir.x == REG_P) x_val = p_plus1;
    if (ir.y == REG_P) y_val = p_plus1;
    if (ir.z == REG_P) z_val = p_plus1;
  end

  // The t field only changes which operand sits on each ALU input; the
  // addition feeding the right-hand input is shared.
  always_comb begin
    alu_a = x_val;
    alu_b = y_val + imm12_val;
    case (t_e'(ir.t))
      T_X_OP_YI: begin alu_a = x_val;     alu_b = y_val + imm12_val; end
      T_X_OP_IY: begin alu_a = x_val;     alu_b = imm12_val + y_val; end
      T_I_OP_XY: begin alu_a = imm12_val; alu_b = x_val + y_val;     end
      default:   begin alu_a = x_val;     alu_b = y_val + imm12_val; end
    endcase
  end

  tenyr_alu u_alu (
    .op_i (ir.op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  assign rhs = (t_e'(ir.t) == T_X_I20) ? (x_val + imm20_val) : alu_y;

  // ---------------------------------------------------------------------------
  // Single RAM port: FETCH reads at P, EXEC reads (load) or writes (store).
  // A store is suppressed on a reset edge so reset cancels it.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_we;
  logic          ram_re;

  always_comb begin
    ram_addr  = regs_q[REG_P][AW-1:0];
    ram_wdata = rhs;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ram_addr = regs_q[REG_P][AW-1:0];
        ram_re   = (halt == '0);
      end
      ST_EXEC: begin
        case (dd_e'(ir.dd))
          DD_STORE_Z: begin
            ram_addr  = rhs[AW-1:0];
            ram_wdata = z_val;
            ram_we    = reset_n;
          end
          DD_STORE_RHS: begin
            ram_addr  = z_val[AW-1:0];
            ram_wdata = rhs;
            ram_we    = reset_n;
          end
          DD_LOAD: begin
            ram_addr = rhs[AW-1:0];
            ram_re   = 1'b1;
          end
          default: begin
            ram_addr = rhs[AW-1:0];
          end
        endcase
      end
      default: begin
        ram_addr = regs_q[REG_P][AW-1:0];
      end
    endcase
  end

  // Read-first: a read and write to the same word on one edge returns old data.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_addr] <= ram_wdata;
    if (ram_re) rdata_q <= ram_q[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Core FSM and register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      ld_z_q  <= REG_A;
      for (int i = 0; i < 15; i++) regs_q[i] <= 32'h0;
      regs_q[REG_P] <= RESET_VECTOR;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // Halt is only honoured here; nothing changes while it is set.
          if (halt == '0) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dd_e'(ir.dd) == DD_LOAD) begin
            ld_z_q  <= ir.z;
            state_q <= ST_LOAD;
          end else begin
            // Default P advance; a register write to P below overrides it.
            regs_q[REG_P] <= p_plus1;
            if (dd_e'(ir.dd) == DD_REG && ir.z != REG_A) regs_q[ir.z] <= rhs;
            state_q <= ST_FETCH;
          end
        end
        ST_LOAD: begin
          regs_q[REG_P] <= p_plus1;
          if (ld_z_q != REG_A) regs_q[ld_z_q] <= rdata_q;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tenyr.sv
// -----------------------------------------------------------------------------
// tb_tenyr
// Bench for the tenyr system. A behavioural instruction-set model (whole
// instructions at a time over plain arrays) predicts registers, RAM and the
// cycle count of each instruction; the DUT is run for exactly that many cycles
// and then parked with halt so its state can be compared.
// -----------------------------------------------------------------------------
module tb_tenyr;
  import tenyr_pkg::*;

  localparam int          DEPTH = 16384;
  localparam logic [31:0] RV    = 32'h0000_1000;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] halt    = 2'b01;

  always #5 clk = ~clk;

  tenyr #(.RAM_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .halt    (halt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [16];
  logic [31:0] m_mem  [DEPTH];

  function automatic int m_idx(input logic [31:0] a);
    return int'(a % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] m_rd(input logic [3:0] r);
    if (r == 4'd0)  return 32'h0;
    if (r == 4'd15) return m_regs[15] + 32'd1;
    return m_regs[r];
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned        s;
    logic signed [31:0] sa, sb;
    s  = b % 32;
    sa = a;
    sb = b;
    case (op)
      4'h0: return a | b;
      4'h1: return a & b;
      4'h2: return a ^ b;
      4'h3: return sa >>> s;
      4'h4: return a + b;
      4'h5: return a * b;
      4'h6: return (a == b) ? 32'hFFFF_FFFF : 32'h0;
      4'h7: return (sa < sb) ? 32'hFFFF_FFFF : 32'h0;
      4'h8: return a | ~b;
      4'h9: return a & ~b;
      4'hA: return (a << 12) | (b & 32'h0000_0FFF);
      4'hB: return (((a >> s) & 32'd1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      4'hC: return a - b;
      4'hD: return a << s;
      4'hE: return (sa >= sb) ? 32'hFFFF_FFFF : 32'h0;
      default: return a >> s;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
    m_regs[15] = RV;
  endtask

  // Executes one whole instruction; returns how many clocks it takes.
  task automatic m_step(output int cyc);
    logic [31:0] insn, x, y, z, i12, i20, rhs, wval, pnext;
    logic [1:0]  t, dd;
    logic [3:0]  zi, xi, yi, op;
    insn = m_mem[m_idx(m_regs[15])];
    t  = insn[31:30];
    dd = insn[29:28];
    zi = insn[27:24];
    xi = insn[23:20];
    yi = insn[19:16];
    op = insn[15:12];
    i12 = {{20{insn[11]}}, insn[11:0]};
    i20 = {{12{insn[19]}}, insn[19:0]};
    x = m_rd(xi);
    y = m_rd(yi);
    z = m_rd(zi);
    case (t)
      2'd0:    rhs = m_alu(op, x, y + i12);
      2'd1:    rhs = m_alu(op, x, i12 + y);
      2'd2:    rhs = m_alu(op, i12, x + y);
      default: rhs = x + i20;
    endcase
    pnext = m_regs[15] + 32'd1;
    wval  = rhs;
    if (dd == 2'd1) m_mem[m_idx(rhs)] = z;
    if (dd == 2'd2) m_mem[m_idx(z)] = rhs;
    if (dd == 2'd3) wval = m_mem[m_idx(rhs)];
    if (dd == 2'd0 || dd == 2'd3) begin
      if (zi == 4'd15)     pnext = wval;
      else if (zi != 4'd0) m_regs[zi] = wval;
    end
    m_regs[15] = pnext;
    cyc = (dd == 2'd3) ? 3 : 2;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Reset for 3 cycles with halt[0] set, loading the model image into the RAM.
  // Returns at a falling edge with reset released and halt still set.
  task automatic start_prog();
    @(negedge clk);
    reset_n = 1'b0;
    halt    = 2'b01;
    for (int i = 0; i < DEPTH; i++) dut.ram_q[i] <= m_mem[i];
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
  endtask

  // Runs n instructions for exactly the model's cycle count, then parks the
  // core with halt[1] before its next fetch.
  task automatic run_n(input int n);
    int cyc, c;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      m_step(c);
      cyc += c;
    end
    halt = 2'b00;
    repeat (cyc) @(negedge clk);
    halt = 2'b10;
  endtask

  task automatic compare_all(input string tag);
    int diffs;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(m_regs[i]);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_r%0d", tag, i), dut.regs_q[i], exp_q.pop_front());
    check($sformatf("%s_state", tag), 32'(dut.state_q), 32'(ST_FETCH));
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.ram_q[i] !== m_mem[i]) diffs++;
    check($sformatf("%s_ramdiffs", tag), 32'(diffs), 32'h0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = $urandom;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // ---- reset with halt[0], then directed program ----
    fill_random();
    m_mem[32'h1000] = 32'h01004005;  // B <- A + 5
    m_mem[32'h1001] = 32'hC2001234;  // C <- 0x1234
    m_mem[32'h1002] = 32'h12004100;  // C -> [A + 0x100]
    m_mem[32'h1003] = 32'h33004100;  // D <- [A + 0x100]
    m_mem[32'h1004] = 32'hC1000003;  // B <- 3
    m_mem[32'h1005] = 32'hC2000005;  // C <- 5
    m_mem[32'h1006] = 32'h03127000;  // D <- B lt C
    m_mem[32'h1007] = 32'h0FF34004;  // P <- P + (D + 4)
    m_mem[32'h1008] = 32'h01004077;  // skipped
    m_mem[32'h1009] = 32'h01004077;  // skipped
    m_mem[32'h100A] = 32'h01004077;  // skipped
    m_mem[32'h100B] = 32'hC0000007;  // A <- 7 (discarded)
    m_mem[32'h100C] = 32'h04004009;  // E <- A + 9
    m_mem[32'h100D] = 32'hC50FFFFF;  // F <- -1
    m_mem[32'h100E] = 32'h06504001;  // G <- F + 1
    start_prog();
    @(negedge clk);                  // cycle 4: halt[0] still high
    check("rst_P", dut.regs_q[15], 32'h0000_1000);
    compare_all("rst");

    run_n(1);
    check("alu_imm_B", dut.regs_q[1], 32'h5);
    check("alu_imm_P", dut.regs_q[15], 32'h0000_1001);
    compare_all("alu_imm");

    run_n(2);
    check("store_mem100", dut.ram_q[32'h100], 32'h0000_1234);
    run_n(1);
    check("load_D", dut.regs_q[3], 32'h0000_1234);
    compare_all("ldst");

    run_n(3);
    check("lt_D", dut.regs_q[3], 32'hFFFF_FFFF);
    run_n(1);
    check("branch_P", dut.regs_q[15], 32'h0000_100B);
    run_n(4);
    check("regA_zero", dut.regs_q[0], 32'h0);
    check("regA_read", dut.regs_q[4], 32'h9);
    check("wrap_G", dut.regs_q[6], 32'h0);
    check("skip_B", dut.regs_q[1], 32'h3);
    compare_all("branch");

    // ---- external halt raised during EXEC of an add ----
    fill_random();
    m_mem[32'h1000] = 32'h01004005;  // B <- A + 5
    m_mem[32'h1001] = 32'h02104002;  // C <- B + 2
    m_mem[32'h1002] = 32'h03224000;  // D <- C + C
    start_prog();
    halt = 2'b00;
    @(negedge clk);                  // add fetched, now in EXEC
    halt = 2'b10;
    begin
      int c;
      m_step(c);
    end
    repeat (6) @(negedge clk);
    check("halt_B", dut.regs_q[1], 32'h5);
    check("halt_P", dut.regs_q[15], 32'h0000_1001);
    compare_all("halt_hold");
    run_n(2);
    check("resume_D", dut.regs_q[3], 32'd14);
    compare_all("resume");

    // ---- reset during EXEC of a store cancels the write ----
    fill_random();
    m_mem[0]        = 32'hA5A5_A5A5;
    m_mem[32'h1000] = 32'hE000_0055;  // [A] <- A + 0x55, address 0
    start_prog();
    halt = 2'b00;
    @(negedge clk);                   // store in EXEC
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_cancel_mem0", dut.ram_q[0], 32'hA5A5_A5A5);
    check("rst_cancel_P", dut.regs_q[15], 32'h0000_1000);
    reset_n = 1'b1;
    m_reset();
    run_n(1);
    check("store_zA_mem0", dut.ram_q[0], 32'h0000_0055);
    compare_all("rst_cancel");

    // ---- random programs over a random memory image ----
    for (int r = 0; r < 3; r++) begin
      fill_random();
      start_prog();
      for (int k = 0; k < 4; k++) begin
        run_n(100);
        compare_all($sformatf("rand%0d_%0d", r, k));
      end
    end

    // ---- reset after activity clears B..O, loads P, keeps RAM ----
    @(negedge clk);
    reset_n = 1'b0;
    halt    = 2'b01;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    @(negedge clk);
    compare_all("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
